// File: rtl/activate_backward.sv
// Backward pass of the vector tanh stage: dx[i] = g[i] * (1 - y[i]^2) in signed fixed point,
// computed one element at a time with a shared square step and a shared scale step.
module activate_backward #(
  parameter int INPUT_SIZE = 20,
  parameter int BW         = 32,
  parameter int FRAC_BITS  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INPUT_SIZE*BW-1:0] y_bus,
  input  logic [INPUT_SIZE*BW-1:0] grad_bus,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INPUT_SIZE*BW-1:0] dx_bus,
  output logic                     clamp_flag
);

  localparam int N  = INPUT_SIZE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int W2 = 2 * BW;
  localparam logic signed [W2-1:0] ONE_W   = W2'(1) << FRAC_BITS;
  localparam logic signed [W2-1:0] SAT_MAX = {{(BW+1){1'b0}}, {(BW-1){1'b1}}};
  localparam logic signed [W2-1:0] SAT_MIN = {{(BW+1){1'b1}}, {(BW-1){1'b0}}};
  localparam logic [IW-1:0]        IDX_LAST = IW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_SQUARE, S_SCALE, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [N*BW-1:0]    y_q, y_d, g_q, g_d, dx_q, dx_d;
  logic [BW-1:0]      d_q, d_d;
  logic               clamp_q, clamp_d;

  int                     slot;
  logic signed [BW-1:0]   y_el, g_el;
  logic signed [W2-1:0]   y_sq, sq, diff, g_prod, p;
  logic [BW-1:0]          p_sat;

  // Element 0 sits in the most significant slot of every bus.
  always_comb begin
    slot   = (N - 1 - int'(idx_q)) * BW;
    y_el   = y_q[slot +: BW];
    g_el   = g_q[slot +: BW];
    y_sq   = W2'(y_el) * W2'(y_el);
    sq     = y_sq >>> FRAC_BITS;
    diff   = ONE_W - sq;
    g_prod = W2'(g_el) * $signed(W2'(d_q));
    p      = g_prod >>> FRAC_BITS;
    if (p > SAT_MAX)      p_sat = SAT_MAX[BW-1:0];
    else if (p < SAT_MIN) p_sat = SAT_MIN[BW-1:0];
    else                  p_sat = p[BW-1:0];
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    idx_d   = idx_q;
    y_d     = y_q;
    g_d     = g_q;
    dx_d    = dx_q;
    d_d     = d_q;
    clamp_d = clamp_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          y_d     = y_bus;
          g_d     = grad_bus;
          idx_d   = '0;
          clamp_d = 1'b0;
          state_d = S_SQUARE;
        end
      end
      S_SQUARE: begin
        if (diff < 0) begin
          d_d     = '0;
          clamp_d = 1'b1;
        end else begin
          d_d = diff[BW-1:0];
        end
        state_d = S_SCALE;
      end
      S_SCALE: begin
        dx_d[slot +: BW] = p_sat;
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = S_SQUARE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data registers are reset too, because the result bus must read zero after reset.
      state_q <= S_IDLE;
      idx_q   <= '0;
      y_q     <= '0;
      g_q     <= '0;
      dx_q    <= '0;
      d_q     <= '0;
      clamp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      g_q     <= g_d;
      dx_q    <= dx_d;
      d_q     <= d_d;
      clamp_q <= clamp_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign dx_bus     = dx_q;
  assign clamp_flag = clamp_q;

endmodule

// File: tb/tb_activate_backward.sv
// Directed bench for activate_backward with hand-computed Q16.16 expectations.
module tb_activate_backward;

  localparam int N  = 20;
  localparam int BW = 32;
  localparam int LAT = 2 * N;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N*BW-1:0] y_bus = '0;
  logic [N*BW-1:0] grad_bus = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [N*BW-1:0] dx_bus;
  logic            clamp_flag;

  always #5 clk = ~clk;

  activate_backward #(.INPUT_SIZE(N), .BW(BW), .FRAC_BITS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_bus     (y_bus),
    .grad_bus  (grad_bus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dx_bus    (dx_bus),
    .clamp_flag(clamp_flag)
  );

  int checks = 0;
  int failures = 0;

  logic [BW-1:0]   y_v[N], g_v[N], e_v[N];
  logic [N*BW-1:0] y_p, g_p, e_p;

  task automatic check(input string tag, input logic [N*BW-1:0] obs, input logic [N*BW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pack_vectors();
    for (int i = 0; i < N; i++) begin
      y_p[(N-1-i)*BW +: BW] = y_v[i];
      g_p[(N-1-i)*BW +: BW] = g_v[i];
      e_p[(N-1-i)*BW +: BW] = e_v[i];
    end
  endtask

  // y = 0 gives 1 - y^2 = 1, so dx equals g.
  task automatic set_plain(input logic [BW-1:0] g);
    for (int i = 0; i < N; i++) begin
      y_v[i] = '0; g_v[i] = g; e_v[i] = g;
    end
    pack_vectors();
  endtask

  task automatic set_mixed();
    for (int i = 0; i < N; i++) begin
      y_v[i] = '0; g_v[i] = BW'(i << 12); e_v[i] = BW'(i << 12);
    end
    y_v[0]  = 32'h0000_8000; g_v[0]  = 32'h0002_0000; e_v[0]  = 32'h0001_8000;
    y_v[1]  = 32'hFFFF_8000; g_v[1]  = 32'hFFFF_0000; e_v[1]  = 32'hFFFF_4000;
    y_v[2]  = 32'h0000_0001; g_v[2]  = 32'h0001_0000; e_v[2]  = 32'h0001_0000;
    y_v[3]  = 32'h0000_C000; g_v[3]  = 32'hFFFF_FFFF; e_v[3]  = 32'hFFFF_FFFF;
    y_v[4]  = 32'h0000_C000; g_v[4]  = 32'h0000_0001; e_v[4]  = 32'h0000_0000;
    y_v[5]  = 32'h0000_C000; g_v[5]  = 32'h0001_0000; e_v[5]  = 32'h0000_7000;
    y_v[6]  = 32'hFFFF_0000; g_v[6]  = 32'h0001_2345; e_v[6]  = 32'h0000_0000;
    y_v[19] = 32'h0001_0000; g_v[19] = 32'h0003_0000; e_v[19] = 32'h0000_0000;
    pack_vectors();
  endtask

  task automatic set_clamp();
    set_plain(32'h0001_0000);
    y_v[3] = 32'h0001_8000; g_v[3] = 32'h0005_0000; e_v[3] = 32'h0000_0000;
    pack_vectors();
  endtask

  // Accepts one vector and returns the cycle count from accept edge to out_valid (-1 on timeout).
  // With pulse set, a different vector is offered on in_valid while the block is busy.
  task automatic send(input logic [N*BW-1:0] y, input logic [N*BW-1:0] g, input bit pulse,
                      output int lat);
    y_bus = y; grad_bus = g; in_valid = 1'b1;
    lat = -1;
    for (int t = 0; t < 200 && !in_ready; t++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (pulse) begin
      y_bus = '1; grad_bus = {N{32'h0005_0000}};
    end
    for (int c = 1; c <= 200; c++) begin
      if (pulse) in_valid = (c >= 3 && c < 12);
      @(posedge clk); #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_handshake_out_valid", N*BW'(out_valid), '0);
    check("post_handshake_in_ready", N*BW'(in_ready), N*BW'(1));
  endtask

  int lat;
  int acc[3];
  int n_acc;
  int cyc;

  initial begin
    #12;
    check("reset_out_valid", N*BW'(out_valid), '0);
    check("reset_in_ready", N*BW'(in_ready), N*BW'(1));
    check("reset_dx_bus", dx_bus, '0);
    check("reset_clamp", N*BW'(clamp_flag), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // All y = 0, g = 1.0.
    set_plain(32'h0001_0000);
    send(y_p, g_p, 1'b0, lat);
    check("plain_latency", N*BW'(lat), N*BW'(LAT));
    check("plain_dx", dx_bus, e_p);
    check("plain_clamp", N*BW'(clamp_flag), '0);
    consume();

    // Mixed values, busy-time input ignored, then held under backpressure.
    set_mixed();
    send(y_p, g_p, 1'b1, lat);
    check("mixed_latency", N*BW'(lat), N*BW'(LAT));
    check("mixed_el0", N*BW'(dx_bus[N*BW-1 -: BW]), N*BW'(32'h0001_8000));
    check("mixed_el1", N*BW'(dx_bus[(N-1)*BW-1 -: BW]), N*BW'(32'hFFFF_4000));
    check("mixed_el19", N*BW'(dx_bus[BW-1:0]), '0);
    check("mixed_dx", dx_bus, e_p);
    check("mixed_clamp", N*BW'(clamp_flag), '0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_dx", dx_bus, e_p);
      check("bp_out_valid", N*BW'(out_valid), N*BW'(1));
      check("bp_in_ready", N*BW'(in_ready), '0);
    end
    consume();

    // Clamp on |y| > 1, then a clean vector clears the flag.
    set_clamp();
    send(y_p, g_p, 1'b0, lat);
    check("clamp_latency", N*BW'(lat), N*BW'(LAT));
    check("clamp_dx", dx_bus, e_p);
    check("clamp_flag_set", N*BW'(clamp_flag), N*BW'(1));
    consume();
    set_plain(32'h0001_0000);
    send(y_p, g_p, 1'b0, lat);
    check("clean_dx", dx_bus, e_p);
    check("clean_flag_cleared", N*BW'(clamp_flag), '0);
    consume();

    // Reset 15 cycles into a clamping vector.
    set_clamp();
    y_bus = y_p; grad_bus = g_p; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", N*BW'(out_valid), '0);
    check("midrst_dx_bus", dx_bus, '0);
    check("midrst_in_ready", N*BW'(in_ready), N*BW'(1));
    check("midrst_clamp", N*BW'(clamp_flag), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_plain(32'h0000_4000);
    send(y_p, g_p, 1'b0, lat);
    check("after_rst_latency", N*BW'(lat), N*BW'(LAT));
    check("after_rst_dx", dx_bus, e_p);
    consume();

    // Back-to-back vectors with both handshakes held high.
    set_plain(32'h0002_0000);
    y_bus = y_p; grad_bus = g_p;
    out_ready = 1'b1; in_valid = 1'b1;
    n_acc = 0; cyc = 0;
    for (int t = 0; t < 300 && n_acc < 3; t++) begin
      if (in_ready) begin
        acc[n_acc] = cyc + 1;
        n_acc++;
      end
      if (out_valid) check("tp_dx", dx_bus, e_p);
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("tp_accepts", N*BW'(n_acc), N*BW'(3));
    if (n_acc == 3) begin
      check("tp_spacing_1", N*BW'(acc[1] - acc[0]), N*BW'(LAT + 2));
      check("tp_spacing_2", N*BW'(acc[2] - acc[1]), N*BW'(LAT + 2));
    end
    for (int t = 0; t < 100 && !in_ready; t++) begin
      @(posedge clk); #1;
    end
    check("tp_drained", N*BW'(in_ready), N*BW'(1));
    out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
